alu_mul_seq: RTL and testbench

//   Sequential unsigned shift-add multiplier that drives the team's combinational ALU as its datapath.
//   It issues operands and opcodes on the alu_* ports and consumes the ALU result and zero flag.
//   It computes a 2*WIDTH-bit product over WIDTH add cycles plus one flag cycle.

---
 rtl/alu_mul_seq_pkg.sv | 17 +
 rtl/alu.sv | 28 ++
 rtl/alu_mul_seq.sv | 98 +++++++++
 tb/tb_alu_mul_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// rtl/alu_mul_seq_pkg.sv - ALU opcodes and multiplier FSM state encodings
package alu_mul_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADD  = 2'b01,
        S_FLAG = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU driven by the sequential multiplier
module alu
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             z
);

    always_comb begin
        y = '0;
        case (f)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

    assign z = (y == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier using an external ALU as datapath
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     m,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_f,
    input  logic [WIDTH-1:0]     alu_y,
    input  logic                 alu_z
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   x_reg;
    logic [CNT_W-1:0]   cnt;
    logic               carry;

    // The ALU has no carry-out; a wrapped sum is always smaller than hi.
    assign carry   = (alu_y < hi);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign product = {hi, lo};

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = ALU_ADD;
        case (state)
            S_ADD: begin
                alu_a = hi;
                alu_b = lo[0] ? x_reg : '0;
                alu_f = ALU_ADD;
            end
            S_FLAG: begin
                alu_a = hi;
                alu_b = lo;
                alu_f = ALU_OR;
            end
            default: begin
                alu_a = '0;
                alu_b = '0;
                alu_f = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hi    <= '0;
            lo    <= '0;
            x_reg <= '0;
            cnt   <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        lo    <= m;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    {hi, lo} <= {carry, alu_y, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FLAG;
                    end
                end
                S_FLAG: begin
                    zero  <= alu_z;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq with a behavioural model
module tb_alu_mul_seq;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   m = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           zero;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_f;
    logic [W-1:0]   alu_y;
    logic           alu_z;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    alu #(.WIDTH(W)) u_alu (
        .a(alu_a), .b(alu_b), .f(alu_f), .y(alu_y), .z(alu_z)
    );

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .m(m),
        .busy(busy), .done(done), .product(product), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: cycles elapsed since the accepting edge (0 = idle). An operation lasts
    // WIDTH add cycles, one flag cycle and one done cycle.
    int          age = 0;
    int          pend = 0;
    int          exp_prod = 0;
    logic        exp_zero = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age = 0;
            exp_prod = 0;
            exp_zero = 1'b0;
        end else if (age == 0) begin
            if (start) begin
                age  = 1;
                pend = int'(x) * int'(m);
            end
        end else if (age == W + 2) begin
            age = 0;
        end else begin
            age = age + 1;
            if (age == W + 2) begin
                exp_prod = pend;
                exp_zero = (pend == 0);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(age != 0));
        check("done", 32'(done), 32'(age == W + 2));
        check("alu_f", 32'(alu_f), (age == W + 1) ? 32'd3 : 32'd0);
        check("zero", 32'(zero), 32'(exp_zero));
        if (age == 0 || age == W + 2) check("product", 32'(product), 32'(exp_prod));
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 30) begin
            tick();
            cycles++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] mv,
                          input logic [2*W-1:0] exp_p, input logic exp_z, input string tag);
        int cyc;
        start = 1'b1; x = xv; m = mv;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        tick();
    endtask

    initial begin
        int cyc;
        int d0;
        int done_at[$];
        int idle_between;
        logic [W-1:0] rx, rm;

        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        tick();

        run_op(6'd63, 6'd63, 12'hF81, 1'b0, "max");
        run_op(6'd0, 6'd37, 12'h000, 1'b1, "x0");
        run_op(6'd37, 6'd0, 12'h000, 1'b1, "m0");
        run_op(6'd5, 6'd3, 12'h00F, 1'b0, "five3");

        // start pulses during ADD are ignored
        d0 = done_cnt;
        start = 1'b1; x = 6'd5; m = 6'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; x = 6'd9; m = 6'd9;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("ignore_product", 32'(product), 32'h00F);
        repeat (12) tick();
        check("ignore_done_count", 32'(done_cnt - d0), 32'd1);

        // asynchronous reset mid-ADD abandons the operation
        start = 1'b1; x = 6'd63; m = 6'd63;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        d0 = done_cnt;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(6'd2, 6'd7, 12'h00E, 1'b0, "after_rst");

        // start held high: back-to-back operations
        start = 1'b1; x = 6'd1; m = 6'd1;
        idle_between = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                done_at.push_back(i);
                check("b2b_product", 32'(product), 32'h001);
            end
            if (done_at.size() == 1 && !busy) idle_between++;
        end
        start = 1'b0;
        check("b2b_count", 32'(done_at.size() >= 3), 32'd1);
        if (done_at.size() >= 3) begin
            check("b2b_period1", 32'(done_at[1] - done_at[0]), 32'd9);
            check("b2b_period2", 32'(done_at[2] - done_at[1]), 32'd9);
        end
        check("b2b_idle_gap", 32'(idle_between), 32'd1);
        repeat (12) tick();

        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom_range(0, 63));
            rm = W'($urandom_range(0, 63));
            if (i % 10 == 0) rx = '0;
            if (i % 10 == 5) rm = 6'd63;
            run_op(rx, rm, 12'(int'(rx) * int'(rm)), (rx == 0) || (rm == 0), "rand");
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
